// File: rtl/logic_op_sequencer.sv
// Issue stage for the 8-bit logical unit: queues {op, a, b} requests, issues one
// operation at a time, samples the opcode's result port and returns it via valid/ready.
module logic_op_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_a,
  input  logic [7:0]               in_b,
  input  logic [2:0]               in_op,
  output logic [7:0]               a,
  output logic [7:0]               b,
  output logic [2:0]               P,
  output logic                     el,
  input  logic [7:0]               A,
  input  logic [7:0]               B,
  input  logic [7:0]               C,
  input  logic [7:0]               D,
  input  logic [7:0]               E,
  input  logic [7:0]               F,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_result,
  output logic [2:0]               out_op,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t        r_state;
  logic [18:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [18:0]   w_head;

  function automatic logic f_legal(input logic [2:0] op);
    return (op != 3'b011) && (op != 3'b100);
  endfunction

  function automatic logic [7:0] f_select(
    input logic [2:0] op,
    input logic [7:0] pa, input logic [7:0] pb, input logic [7:0] pc,
    input logic [7:0] pd, input logic [7:0] pe, input logic [7:0] pf
  );
    logic [7:0] res;
    res = 8'h00;
    case (op)
      3'b101:  res = pa;
      3'b110:  res = pb;
      3'b111:  res = pc;
      3'b000:  res = pd;
      3'b001:  res = pe;
      3'b010:  res = pf;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  // Readiness comes from the registered level only, so a pop never frees a slot early.
  assign in_ready = !w_full && !rst;
  assign w_push   = in_valid && in_ready;
  assign w_head   = r_mem[r_rptr];
  assign w_pop    = !w_empty && ((r_state == S_IDLE) ||
                    ((r_state == S_HOLD) && out_valid && out_ready));
  assign count    = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {in_op, in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // el is registered and driven low on entry to ISSUE only for legal opcodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      el         <= 1'b1;
      a          <= 8'h00;
      b          <= 8'h00;
      P          <= 3'b000;
      out_valid  <= 1'b0;
      out_result <= 8'h00;
      out_op     <= 3'b000;
      out_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          el <= 1'b1;
          if (w_pop) begin
            P       <= w_head[18:16];
            a       <= w_head[15:8];
            b       <= w_head[7:0];
            el      <= !f_legal(w_head[18:16]);
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          out_valid  <= 1'b1;
          out_op     <= P;
          out_err    <= !f_legal(P);
          out_result <= f_legal(P) ? f_select(P, A, B, C, D, E, F) : 8'h00;
          el         <= 1'b1;
          r_state    <= S_HOLD;
        end
        S_HOLD: begin
          el <= 1'b1;
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (w_pop) begin
              P       <= w_head[18:16];
              a       <= w_head[15:8];
              b       <= w_head[7:0];
              el      <= !f_legal(w_head[18:16]);
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          el      <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
